cmp_unit_iter: RTL and testbench

//  Parametrised, iterative compare unit for the ALU datapath: compares two WIDTH-bit operands

---
 rtl/cmp_unit_iter.sv | 138 +++++++++++++
 tb/tb_cmp_unit_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_unit_iter.sv
// Iterative MSB-first digit comparator with early exit and busy/done handshake.
// Optional two's-complement mode is compiled in with the CMP_SIGNED_EN macro.
module cmp_unit_iter #(
    parameter int WIDTH     = 16,
    parameter int DIGIT_W   = 4,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_cmp,
    input  logic [WIDTH-1:0]     a_cmp,
    input  logic [WIDTH-1:0]     b_cmp,
    input  logic [2:0]           alu_fun_cmp,
    input  logic                 cmp_enable,
`ifdef CMP_SIGNED_EN
    input  logic                 cmp_signed,
`endif
    output logic [OUT_WIDTH-1:0] cmp_out,
    output logic                 cmp_flag,
    output logic                 cmp_busy
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] SIGN_MSK = {1'b1, {(WIDTH-1){1'b0}}};

    // Handshake: a request is taken on any edge where cmp_enable=1 and cmp_busy=0;
    // the result is valid in the single cycle cmp_flag=1, and cmp_out then holds it.
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [NDIG-1:0][DIGIT_W-1:0] a_q, b_q;
    logic [2:0]                   fun_q;
    logic [IDX_W-1:0]             idx_q;
    logic [OUT_WIDTH-1:0]         out_q;
    logic                         accept, idx_dec, res_load;
    logic [2:0]                   res_code;
    logic [DIGIT_W-1:0]           dig_a, dig_b;
    logic [WIDTH-1:0]             a_in, b_in;

    // Offset-binary: flipping both sign bits turns a signed compare into an unsigned one.
`ifdef CMP_SIGNED_EN
    assign a_in = cmp_signed ? (a_cmp ^ SIGN_MSK) : a_cmp;
    assign b_in = cmp_signed ? (b_cmp ^ SIGN_MSK) : b_cmp;
`else
    assign a_in = a_cmp;
    assign b_in = b_cmp;
`endif

    assign dig_a = a_q[idx_q];
    assign dig_b = b_q[idx_q];

    function automatic logic [2:0] code_of(input logic [2:0] fun, input logic gt, input logic lt);
        logic eq;
        eq      = !gt && !lt;
        code_of = 3'd0;
        case (fun)
            3'd1:    if (eq)  code_of = 3'd1;
            3'd2:    if (gt)  code_of = 3'd2;
            3'd3:    if (lt)  code_of = 3'd3;
            3'd4:    if (!eq) code_of = 3'd4;
            3'd5:    if (!lt) code_of = 3'd5;
            3'd6:    if (!gt) code_of = 3'd6;
            default: code_of = 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_cmp) begin
        if (!rst_cmp) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        idx_dec  = 1'b0;
        res_load = 1'b0;
        res_code = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (cmp_enable) begin
                    accept = 1'b1;
                    if (alu_fun_cmp == 3'd0 || alu_fun_cmp == 3'd7) begin
                        state_d  = S_DONE;
                        res_load = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (dig_a != dig_b) begin
                    res_load = 1'b1;
                    res_code = code_of(fun_q, dig_a > dig_b, dig_a < dig_b);
                    state_d  = S_DONE;
                end else if (idx_q == '0) begin
                    res_load = 1'b1;
                    res_code = code_of(fun_q, 1'b0, 1'b0);
                    state_d  = S_DONE;
                end else begin
                    idx_dec = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_cmp) begin
        if (!rst_cmp) begin
            a_q   <= '0;
            b_q   <= '0;
            fun_q <= 3'd0;
            idx_q <= IDX_TOP;
            out_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= a_in;
                b_q   <= b_in;
                fun_q <= alu_fun_cmp;
                idx_q <= IDX_TOP;
            end else if (idx_dec) begin
                idx_q <= idx_q - 1'b1;
            end
            if (res_load) begin
                out_q <= OUT_WIDTH'(res_code);
            end
        end
    end

    assign cmp_out  = out_q;
    assign cmp_flag = (state_q == S_DONE);
    assign cmp_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmp_unit_iter.sv
// Bench for cmp_unit_iter: directed and random compares against an arithmetic reference model.
module tb_cmp_unit_iter;
    localparam int WIDTH     = 16;
    localparam int DIGIT_W   = 4;
    localparam int OUT_WIDTH = 4;
    localparam int NDIG      = WIDTH / DIGIT_W;
`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_cmp;
    logic [WIDTH-1:0]     a_cmp, b_cmp;
    logic [2:0]           alu_fun_cmp;
    logic                 cmp_enable;
    logic                 cmp_signed;
    logic [OUT_WIDTH-1:0] cmp_out;
    logic                 cmp_flag;
    logic                 cmp_busy;

    int                   tests = 0;
    int                   fails = 0;
    logic [OUT_WIDTH-1:0] exp_q[$];
    logic [OUT_WIDTH-1:0] prev_out;

    cmp_unit_iter #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk         (clk),
        .rst_cmp     (rst_cmp),
        .a_cmp       (a_cmp),
        .b_cmp       (b_cmp),
        .alu_fun_cmp (alu_fun_cmp),
        .cmp_enable  (cmp_enable),
`ifdef CMP_SIGNED_EN
        .cmp_signed  (cmp_signed),
`endif
        .cmp_out     (cmp_out),
        .cmp_flag    (cmp_flag),
        .cmp_busy    (cmp_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: result code from the numeric values
    function automatic logic [OUT_WIDTH-1:0] exp_code(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                       input logic [2:0] f, input bit sgn);
        longint va, vb;
        int     r;
        va = longint'(a);
        vb = longint'(b);
        if (sgn && a[WIDTH-1]) va = va - (longint'(1) << WIDTH);
        if (sgn && b[WIDTH-1]) vb = vb - (longint'(1) << WIDTH);
        case (f)
            3'd1:    r = (va == vb) ? 1 : 0;
            3'd2:    r = (va >  vb) ? 2 : 0;
            3'd3:    r = (va <  vb) ? 3 : 0;
            3'd4:    r = (va != vb) ? 4 : 0;
            3'd5:    r = (va >= vb) ? 5 : 0;
            3'd6:    r = (va <= vb) ? 6 : 0;
            default: r = 0;
        endcase
        return OUT_WIDTH'(r);
    endfunction

    // reference model: cycles from accept edge to the edge that samples the flag
    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] f);
        logic [WIDTH-1:0] d;
        int               msb;
        if (f == 3'd0 || f == 3'd7) return 1;
        d = a ^ b;
        if (d == '0) return NDIG + 1;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) if (d[i]) msb = i;
        return NDIG - msb / DIGIT_W + 1;
    endfunction

    // driver: one compare, optionally pulsing cmp_enable with a=0 while busy
    task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] f,
                          input bit sgn, input bit noise);
        int lat, c;
        bit got;
        @(negedge clk);
        a_cmp       = a;
        b_cmp       = b;
        alu_fun_cmp = f;
        cmp_signed  = sgn;
        cmp_enable  = 1'b1;
        exp_q.push_back(exp_code(a, b, f, cmp_signed && SIGNED_BUILD));
        lat = exp_lat(a, b, f);
        @(posedge clk);
        #1;
        cmp_enable  = noise;
        a_cmp       = noise ? '0 : WIDTH'($urandom);
        b_cmp       = WIDTH'($urandom);
        alu_fun_cmp = 3'($urandom);
        cmp_signed  = 1'($urandom);
        check("busy_after_accept", {31'd0, cmp_busy}, 32'd1);
        if (lat > 1) check("out_held_during_scan", {28'd0, cmp_out}, {28'd0, prev_out});
        c   = 1;
        got = 1'b0;
        while (!got && c <= NDIG + 3) begin
            if (cmp_flag === 1'b1) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cmp_enable = 1'b0;
                c++;
            end
        end
        check("latency", c, lat);
        prev_out = exp_q.pop_front();
        check("result", {28'd0, cmp_out}, {28'd0, prev_out});
        @(posedge clk);
        #1;
        cmp_enable = 1'b0;
        check("flag_one_cycle", {31'd0, cmp_flag}, 32'd0);
        check("idle_after_done", {31'd0, cmp_busy}, 32'd0);
    endtask

    // driver: cmp_enable held high for n back-to-back compares on fixed operands
    task automatic back_to_back(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] f,
                                input int n);
        int                   k, per, nflags;
        logic [OUT_WIDTH-1:0] code;
        k      = exp_lat(a, b, f) - 1;
        per    = k + 2;
        nflags = 0;
        @(negedge clk);
        a_cmp       = a;
        b_cmp       = b;
        alu_fun_cmp = f;
        cmp_signed  = 1'b0;
        cmp_enable  = 1'b1;
        code        = exp_code(a, b, f, 1'b0);
        @(posedge clk);
        #1;
        for (int c = 1; c <= n * per; c++) begin
            check("b2b_flag", {31'd0, cmp_flag}, ((c - 1) % per == k) ? 32'd1 : 32'd0);
            if (cmp_flag === 1'b1) begin
                nflags++;
                check("b2b_result", {28'd0, cmp_out}, {28'd0, code});
            end
            if (c == n * per) cmp_enable = 1'b0;
            @(posedge clk);
            #1;
        end
        check("b2b_flag_count", nflags, n);
        check("b2b_idle", {31'd0, cmp_busy}, 32'd0);
        prev_out = code;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [2:0]       rf;
        int               mode;

        rst_cmp     = 1'b0;
        cmp_enable  = 1'b0;
        a_cmp       = '0;
        b_cmp       = '0;
        alu_fun_cmp = 3'd0;
        cmp_signed  = 1'b0;
        prev_out    = '0;
        repeat (2) @(negedge clk);
        check("reset_out", {28'd0, cmp_out}, 32'd0);
        check("reset_flag", {31'd0, cmp_flag}, 32'd0);
        check("reset_busy", {31'd0, cmp_busy}, 32'd0);
        rst_cmp = 1'b1;

        // leave a nonzero result, then reset in the middle of a long scan
        do_cmp(16'h0001, 16'h0002, 3'd4, 1'b0, 1'b0);
        @(negedge clk);
        a_cmp       = 16'h1234;
        b_cmp       = 16'h1235;
        alu_fun_cmp = 3'd3;
        cmp_enable  = 1'b1;
        @(posedge clk);
        #1;
        cmp_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_cmp = 1'b0;
        #1;
        check("midreset_out", {28'd0, cmp_out}, 32'd0);
        check("midreset_busy", {31'd0, cmp_busy}, 32'd0);
        check("midreset_flag", {31'd0, cmp_flag}, 32'd0);
        @(negedge clk);
        rst_cmp  = 1'b1;
        prev_out = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_no_flag", {31'd0, cmp_flag}, 32'd0);
            check("post_reset_idle", {31'd0, cmp_busy}, 32'd0);
        end

        // directed ops and boundaries
        do_cmp(16'h1234, 16'h1234, 3'd1, 1'b0, 1'b0);
        do_cmp(16'h1234, 16'h1234, 3'd4, 1'b0, 1'b0);
        do_cmp(16'h8000, 16'h7FFF, 3'd2, 1'b0, 1'b0);
        do_cmp(16'h8000, 16'h7FFF, 3'd3, 1'b0, 1'b0);
        do_cmp(16'h1230, 16'h1231, 3'd6, 1'b0, 1'b1);
        do_cmp(16'hFFFF, 16'hFFFF, 3'd5, 1'b0, 1'b0);
        do_cmp(16'h5A5A, 16'h0000, 3'd0, 1'b0, 1'b1);
        do_cmp(16'h5A5A, 16'h5A5A, 3'd7, 1'b0, 1'b0);

        // held request: exactly one flag per compare, one compare per k+2 cycles
        back_to_back(16'h8000, 16'h7FFF, 3'd2, 3);
        back_to_back(16'h4321, 16'h4321, 3'd1, 2);

        // signed mode (no effect when the feature is compiled out)
        do_cmp(16'h8000, 16'h0001, 3'd3, 1'b1, 1'b0);
        do_cmp(16'h8000, 16'h0001, 3'd3, 1'b0, 1'b0);
        do_cmp(16'h7FFF, 16'hFFFF, 3'd2, 1'b1, 1'b0);

        // random stimulus, biased toward long scans
        for (int i = 0; i < 40; i++) begin
            ra   = WIDTH'($urandom);
            rf   = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 3);
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            else                rb = WIDTH'($urandom);
            do_cmp(ra, rb, rf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
